mul_seq_unit: RTL and testbench
===============================

Name: mul_seq_unit

Overview:
Parametrised multi-cycle multiply unit for the multi-cycle ARM core. It covers MUL, MLA, UMULL, UMLAL, SMULL and SMLAL.
- Latches the instruction on start and decodes the register fields itself.
- Fetches operands over the shared two-port register file.
- Runs an iterative shift-add multiply, then writes back one word (32-bit ops) or two words (long ops) and optional NZ flags.
- The main controller hands off on start and stalls until done.

Parameters:
WIDTH, 32, operand/register width; product is 2*WIDTH
BITS_PER_CYCLE, 1, multiplier bits retired per MULT cycle; legal 1, 2, 4; must divide WIDTH
NITER, WIDTH/BITS_PER_CYCLE, derived (localparam), number of MULT cycles

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
start  in  1  one-cycle request; Instr valid and is a multiply
Instr  in  32  instruction word, sampled only when start accepted
ra1  out  4  register file read address, port 1
ra2  out  4  register file read address, port 2
rd1  in  WIDTH  read data, port 1; combinational from ra1
rd2  in  WIDTH  read data, port 2; combinational from ra2
we  out  1  register write enable
wa  out  4  register write address
wd  out  WIDTH  register write data
flags_we  out  1  NZ update strobe, asserted with the final write when S=1
flag_n  out  1  result sign
flag_z  out  1  result is zero
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse in the final cycle of an operation
err  out  1  pulsed with done for an illegal opcode

Behaviour:
- Reset (async): state IDLE; all outputs 0; internal registers cleared.
- Field decode from latched Instr:
  - op = Instr[23:21]: 000 MUL, 001 MLA, 100 UMULL, 101 UMLAL, 110 SMULL, 111 SMLAL; 010 and 011 are illegal.
  - S = Instr[20]; Rd/RdHi = [19:16]; Rn/RdLo = [15:12]; Rs = [11:8]; Rm = [3:0].
- FSM: IDLE -> FETCH_OP -> [FETCH_ACC] -> MULT -> FIX -> WB_LO -> [WB_HI] -> IDLE.
  - IDLE: start=1 latches Instr. If op is illegal -> ERR, else FETCH_OP.
  - ERR: done=1, err=1, no write -> IDLE.
  - FETCH_OP: ra1=Rm, ra2=Rs; capture rd1 to A, rd2 to B.
    - For signed ops, store |A| and |B| and neg = A[msb]^B[msb].
    - For unsigned ops, neg=0.
  - FETCH_ACC (accumulate ops only):
    - MLA: ra1=Rn; acc = zero-extended rd1.
    - Long accumulate: ra1=RdLo, ra2=RdHi; acc = {rd2, rd1}.
    - Non-accumulate ops: acc = 0.
  - MULT: NITER cycles. Each cycle adds B * A[BITS_PER_CYCLE-1:0], shifted into position, to the 2*WIDTH product, then shifts A right by BITS_PER_CYCLE. Iteration counter ends at NITER-1.
  - FIX: P = (neg ? -prod : prod) + acc, computed modulo 2^(2*WIDTH).
  - WB_LO: we=1, wa = Rd (32-bit ops) or RdLo (long ops), wd = P[WIDTH-1:0].
    - For 32-bit ops this is the final cycle: done=1.
  - WB_HI (long only): we=1, wa=RdHi, wd = P[2*WIDTH-1:WIDTH]; done=1.
- Flags, valid in the final cycle:
  - 32-bit ops: N = P[WIDTH-1], Z = (P[WIDTH-1:0]==0).
  - Long ops: N = P[2*WIDTH-1], Z = (P==0).
  - flags_we = S in the final cycle only.
- ra1/ra2 are 0 outside the FETCH states.
- busy stays high through the done cycle; busy=0 in IDLE.
- Latency (start edge to done cycle):
  - MUL: NITER+3; MLA and UMULL/SMULL: NITER+4; UMLAL/SMLAL: NITER+5.
  - ERR: 1.
- Boundary and corner cases:
  - start while busy: ignored; no re-latch.
  - RdHi==RdLo: both writes issued; the RdHi value wins.
  - Operand registers equal to destination registers: no effect, since operands are captured before any write.
  - Bits 27:24 and 7:4 are not checked; the controller guarantees a multiply.
  - Reset mid-operation: immediate return to IDLE; no further we/done; a write in progress is dropped.

Decomposition:
- Package mul_pkg:
  - Opcode enum (MUL..SMLAL).
  - FSM state enum.
  - Field position constants (OP_HI=23, OP_LO=21, S_BIT=20, RD_HI=19, RN_HI=15, RS_HI=11, RM_HI=3).
  - ILLEGAL opcode set.
- Sub-module mul_iter_core: the shift-add datapath. It holds A, B, product and the counter and exposes load, step and last.
- The top level holds the decode, FSM and register-file sequencing.

Test Plan:
- MUL R2,R3,R4 (Rm=3=7, Rs=4=6), S=1 -> after 35 cycles a single write wa=2, wd=42; flags_we=1, N=0, Z=0; err=0.
- MLA with Rm=0xFFFFFFFF, Rs=2, Rn=5 -> wd=0x00000003 (wraps); latency 36.
- UMULL RdLo=1, RdHi=2, Rm=0xFFFFFFFF, Rs=0xFFFFFFFF -> WB_LO wd=0x00000001, then WB_HI wd=0xFFFFFFFE; done on the second write.
- SMLAL with Rm=-3, Rs=4, acc={0,5} -> P=-7: lo=0xFFFFFFF9, hi=0xFFFFFFFF; with S=1, N=1, Z=0.
- op=010 -> done=err=1 one cycle after start; we never asserted. A start pulse during busy is ignored (count the writes).
- Assert reset during MULT -> all outputs 0 immediately, no writes follow. Repeat the MUL test with BITS_PER_CYCLE=4 and check a latency of 11.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the multi-cycle multiply unit: opcodes, FSM states,
// instruction field positions and small opcode classification helpers.
package mul_pkg;

    localparam int OP_HI = 23;
    localparam int OP_LO = 21;
    localparam int S_BIT = 20;
    localparam int RD_HI = 19;
    localparam int RN_HI = 15;
    localparam int RS_HI = 11;
    localparam int RM_HI = 3;

    typedef enum logic [2:0] {
        OP_MUL   = 3'b000,
        OP_MLA   = 3'b001,
        OP_ILL_A = 3'b010,
        OP_ILL_B = 3'b011,
        OP_UMULL = 3'b100,
        OP_UMLAL = 3'b101,
        OP_SMULL = 3'b110,
        OP_SMLAL = 3'b111
    } mul_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ERR,
        ST_FETCH_OP,
        ST_FETCH_ACC,
        ST_MULT,
        ST_FIX,
        ST_WB_LO,
        ST_WB_HI
    } mul_state_t;

    // One bit per opcode value; a set bit marks an opcode with no multiply meaning.
    localparam logic [7:0] ILLEGAL_OPS = 8'b0000_1100;

    function automatic logic is_illegal(input logic [2:0] op);
        return ILLEGAL_OPS[op];
    endfunction

    function automatic logic is_long(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_acc(input logic [2:0] op);
        return op[0];
    endfunction

    function automatic logic is_signed(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/mul_iter_core.sv
// Iterative shift-add multiplier datapath: retires BITS_PER_CYCLE multiplier
// bits per step into a 2*WIDTH product.
module mul_iter_core #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 last
);

    localparam int NITER = WIDTH / BITS_PER_CYCLE;
    localparam int CW    = (NITER > 1) ? $clog2(NITER) : 1;

    logic [WIDTH-1:0]   a_q;
    // B is kept pre-shifted into the current digit position so no barrel shifter is needed.
    logic [2*WIDTH-1:0] b_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] pp;

    always_comb begin
        pp = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (a_q[i]) begin
                pp = pp + (b_q << i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
            cnt_q  <= '0;
        end else if (load) begin
            a_q    <= a_in;
            b_q    <= {{WIDTH{1'b0}}, b_in};
            prod_q <= '0;
            cnt_q  <= '0;
        end else if (step) begin
            a_q    <= a_q >> BITS_PER_CYCLE;
            b_q    <= b_q << BITS_PER_CYCLE;
            prod_q <= prod_q + pp;
            cnt_q  <= cnt_q + CW'(1);
        end
    end

    assign prod = prod_q;
    assign last = (cnt_q == CW'(NITER - 1));

endmodule

// File: rtl/mul_seq_unit.sv
// Multi-cycle multiply unit (MUL/MLA/UMULL/UMLAL/SMULL/SMLAL): decodes the
// latched instruction, sequences register-file reads, multiplies and writes back.
module mul_seq_unit
    import mul_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      Instr,
    output logic [3:0]       ra1,
    output logic [3:0]       ra2,
    input  logic [WIDTH-1:0] rd1,
    input  logic [WIDTH-1:0] rd2,
    output logic             we,
    output logic [3:0]       wa,
    output logic [WIDTH-1:0] wd,
    output logic             flags_we,
    output logic             flag_n,
    output logic             flag_z,
    output logic             busy,
    output logic             done,
    output logic             err
);

    // Handshake: start is accepted only in IDLE (busy=0) and is ignored otherwise;
    // busy then stays high up to and including the single-cycle done pulse.

    mul_state_t state_q, state_d;

    logic [2:0] op_q;
    logic       s_q;
    logic [3:0] rd_q, rn_q, rs_q, rm_q;
    logic       neg_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] p_q;

    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [2*WIDTH-1:0] prod;
    logic               mult_last;
    logic               core_load, core_step;
    logic               final_cycle;

    // Condition-code and encoding bits are outside the multiply's concern.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{Instr[31:24], Instr[7:4]};

    mul_iter_core #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .load  (core_load),
        .step  (core_step),
        .a_in  (a_abs),
        .b_in  (b_abs),
        .prod  (prod),
        .last  (mult_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (start) state_d = is_illegal(Instr[OP_HI:OP_LO]) ? ST_ERR : ST_FETCH_OP;
            ST_ERR:       state_d = ST_IDLE;
            ST_FETCH_OP:  state_d = is_acc(op_q) ? ST_FETCH_ACC : ST_MULT;
            ST_FETCH_ACC: state_d = ST_MULT;
            ST_MULT:      if (mult_last) state_d = ST_FIX;
            ST_FIX:       state_d = ST_WB_LO;
            ST_WB_LO:     state_d = is_long(op_q) ? ST_WB_HI : ST_IDLE;
            ST_WB_HI:     state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ra1         = '0;
        ra2         = '0;
        we          = 1'b0;
        wa          = '0;
        wd          = '0;
        done        = 1'b0;
        err         = 1'b0;
        core_load   = 1'b0;
        core_step   = 1'b0;
        final_cycle = 1'b0;
        busy        = (state_q != ST_IDLE);
        case (state_q)
            ST_ERR: begin
                done = 1'b1;
                err  = 1'b1;
            end
            ST_FETCH_OP: begin
                ra1       = rm_q;
                ra2       = rs_q;
                core_load = 1'b1;
            end
            ST_FETCH_ACC: begin
                ra1 = rn_q;
                ra2 = is_long(op_q) ? rd_q : 4'd0;
            end
            ST_MULT: core_step = 1'b1;
            ST_WB_LO: begin
                we          = 1'b1;
                wa          = is_long(op_q) ? rn_q : rd_q;
                wd          = p_q[WIDTH-1:0];
                final_cycle = !is_long(op_q);
            end
            ST_WB_HI: begin
                we          = 1'b1;
                wa          = rd_q;
                wd          = p_q[2*WIDTH-1:WIDTH];
                final_cycle = 1'b1;
            end
            default: ;
        endcase
        if (final_cycle) done = 1'b1;
    end

    // Flags reflect the full 64-bit result for long ops, the low word otherwise.
    always_comb begin
        flags_we = final_cycle & s_q;
        flag_n   = 1'b0;
        flag_z   = 1'b0;
        if (final_cycle) begin
            flag_n = is_long(op_q) ? p_q[2*WIDTH-1] : p_q[WIDTH-1];
            flag_z = is_long(op_q) ? (p_q == '0) : (p_q[WIDTH-1:0] == '0);
        end
    end

    always_comb begin
        a_abs = rd1;
        b_abs = rd2;
        if (is_signed(op_q)) begin
            if (rd1[WIDTH-1]) a_abs = -rd1;
            if (rd2[WIDTH-1]) b_abs = -rd2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q  <= '0;
            s_q   <= 1'b0;
            rd_q  <= '0;
            rn_q  <= '0;
            rs_q  <= '0;
            rm_q  <= '0;
            neg_q <= 1'b0;
            acc_q <= '0;
            p_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        op_q <= Instr[OP_HI:OP_LO];
                        s_q  <= Instr[S_BIT];
                        rd_q <= Instr[RD_HI -: 4];
                        rn_q <= Instr[RN_HI -: 4];
                        rs_q <= Instr[RS_HI -: 4];
                        rm_q <= Instr[RM_HI -: 4];
                    end
                end
                ST_FETCH_OP: begin
                    neg_q <= is_signed(op_q) & (rd1[WIDTH-1] ^ rd2[WIDTH-1]);
                    acc_q <= '0;
                end
                ST_FETCH_ACC: begin
                    acc_q <= is_long(op_q) ? {rd2, rd1} : {{WIDTH{1'b0}}, rd1};
                end
                ST_FIX: begin
                    p_q <= (neg_q ? -prod : prod) + acc_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_unit.sv
// Directed bench for mul_seq_unit: register-file model, write scoreboard,
// latency/flag checks, and a second instance with four bits per cycle.
module tb_mul_seq_unit;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic         start, start4;
    logic [31:0]  instr, instr4;
    logic [3:0]   ra1, ra2, wa, ra1_4, ra2_4, wa4;
    logic [W-1:0] rd1, rd2, wd, rd1_4, rd2_4, wd4;
    logic we, flags_we, flag_n, flag_z, busy, done, err;
    logic we4, flags_we4, flag_n4, flag_z4, busy4, done4, err4;

    logic [W-1:0] regs[16];
    logic [W-1:0] regs4[16];

    assign rd1   = regs[ra1];
    assign rd2   = regs[ra2];
    assign rd1_4 = regs4[ra1_4];
    assign rd2_4 = regs4[ra2_4];

    mul_seq_unit #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut (
        .clk(clk), .reset(reset), .start(start), .Instr(instr),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .we(we), .wa(wa), .wd(wd),
        .flags_we(flags_we), .flag_n(flag_n), .flag_z(flag_z),
        .busy(busy), .done(done), .err(err)
    );

    mul_seq_unit #(.WIDTH(W), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .Instr(instr4),
        .ra1(ra1_4), .ra2(ra2_4), .rd1(rd1_4), .rd2(rd2_4),
        .we(we4), .wa(wa4), .wd(wd4),
        .flags_we(flags_we4), .flag_n(flag_n4), .flag_z(flag_z4),
        .busy(busy4), .done(done4), .err(err4)
    );

    always @(posedge clk) begin
        if (we) regs[wa] <= wd;
        if (we4) regs4[wa4] <= wd4;
    end

    int checks = 0;
    int errors = 0;
    int nwrites = 0;

    logic [W-1:0] exp_q[$];
    logic [3:0]   exp_wa_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [2:0] op, input logic s, input logic [3:0] rd,
                                       input logic [3:0] rn, input logic [3:0] rs, input logic [3:0] rm);
        return {4'hE, 4'b0000, op, s, rd, rn, rs, 4'b1001, rm};
    endfunction

    task automatic expect_write(input logic [3:0] a, input logic [W-1:0] d);
        exp_wa_q.push_back(a);
        exp_q.push_back(d);
    endtask

    // Scoreboard: every DUT write must match the oldest expected write.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            logic [W-1:0] ed;
            logic [3:0]   ea;
            nwrites++;
            check("write_pending", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                ed = exp_q.pop_front();
                ea = exp_wa_q.pop_front();
                check("write_wa", 64'(wa), 64'(ea));
                check("write_wd", 64'(wd), 64'(ed));
            end
        end
    end

    task automatic run_op(input string tag, input logic [31:0] ins, input int exp_lat,
                          input logic exp_err, input logic exp_fwe, input logic chk_nz,
                          input logic exp_n, input logic exp_z, input int pulse_at);
        int n;
        @(negedge clk);
        instr = ins;
        start = 1'b1;
        for (n = 1; n <= 200; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 1) begin
                start = 1'b0;
                check($sformatf("%s_busy", tag), 64'(busy), 64'(1));
            end
            if (pulse_at > 1 && n == pulse_at) begin
                instr = mk(3'b000, 1'b1, 4'd9, 4'd0, 4'd0, 4'd0);
                start = 1'b1;
            end else if (pulse_at > 1 && n == pulse_at + 1) begin
                start = 1'b0;
            end
            if (done === 1'b1) break;
        end
        check($sformatf("%s_latency", tag), 64'(n), 64'(exp_lat));
        check($sformatf("%s_err", tag), 64'(err), 64'(exp_err));
        check($sformatf("%s_flags_we", tag), 64'(flags_we), 64'(exp_fwe));
        if (chk_nz) check($sformatf("%s_nz", tag), 64'({flag_n, flag_z}), 64'({exp_n, exp_z}));
        @(negedge clk);
        check($sformatf("%s_drained", tag), 64'(exp_q.size()), 64'(0));
        check($sformatf("%s_idle", tag), 64'({busy, done}), 64'(0));
    endtask

    initial begin
        int w0;
        int n;
        start  = 1'b0;
        start4 = 1'b0;
        instr  = '0;
        instr4 = '0;
        reset  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            regs[i]  <= '0;
            regs4[i] <= '0;
        end
        regs[3]  <= 32'd7;
        regs[4]  <= 32'd6;
        regs[6]  <= 32'd5;
        regs[7]  <= 32'hFFFF_FFFF;
        regs[8]  <= 32'd2;
        regs[9]  <= 32'hFFFF_FFFF;
        regs[10] <= 32'hFFFF_FFFF;
        regs[11] <= 32'd5;
        regs[12] <= 32'd0;
        regs[13] <= 32'hFFFF_FFFD;
        regs[14] <= 32'd4;
        regs4[3] <= 32'd7;
        regs4[4] <= 32'd6;
        #1;
        check("reset_outputs", 64'({busy, done, err, we, flags_we, flag_n, flag_z, ra1, ra2, wa}), 64'(0));
        check("reset_wd", 64'(wd), 64'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;

        expect_write(4'd2, 32'd42);
        run_op("mul", mk(3'b000, 1'b1, 4'd2, 4'd0, 4'd4, 4'd3), 35, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);

        expect_write(4'd5, 32'h0000_0003);
        run_op("mla", mk(3'b001, 1'b0, 4'd5, 4'd6, 4'd8, 4'd7), 36, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        expect_write(4'd1, 32'h0000_0001);
        expect_write(4'd2, 32'hFFFF_FFFE);
        run_op("umull", mk(3'b100, 1'b1, 4'd2, 4'd1, 4'd10, 4'd9), 36, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0);

        expect_write(4'd11, 32'hFFFF_FFF9);
        expect_write(4'd12, 32'hFFFF_FFFF);
        run_op("smlal", mk(3'b111, 1'b1, 4'd12, 4'd11, 4'd14, 4'd13), 37, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0);

        expect_write(4'd6, 32'h0);
        run_op("mul_zero", mk(3'b000, 1'b1, 4'd6, 4'd0, 4'd4, 4'd0), 35, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0);

        expect_write(4'd15, 32'hFFFF_FFF9);
        expect_write(4'd15, 32'h0000_0006);
        run_op("umull_same", mk(3'b100, 1'b0, 4'd15, 4'd15, 4'd9, 4'd3), 36, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("rdhi_wins", 64'(regs[15]), 64'(32'h6));

        expect_write(4'd7, 32'h0000_0003);
        expect_write(4'd8, 32'h0000_0000);
        run_op("smull_negneg", mk(3'b110, 1'b1, 4'd8, 4'd7, 4'd12, 4'd13), 36, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);

        w0 = nwrites;
        run_op("illegal_010", mk(3'b010, 1'b1, 4'd3, 4'd3, 4'd3, 4'd3), 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        run_op("illegal_011", mk(3'b011, 1'b0, 4'd3, 4'd3, 4'd3, 4'd3), 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("illegal_no_write", 64'(nwrites - w0), 64'(0));

        w0 = nwrites;
        expect_write(4'd10, 32'd42);
        run_op("start_busy", mk(3'b000, 1'b0, 4'd10, 4'd0, 4'd4, 4'd3), 35, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5);
        check("start_busy_writes", 64'(nwrites - w0), 64'(1));

        // Reset in the middle of MULT: outputs drop at once and the write never happens.
        @(negedge clk);
        instr = mk(3'b000, 1'b0, 4'd14, 4'd0, 4'd4, 4'd3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_busy", 64'(busy), 64'(1));
        w0 = nwrites;
        reset = 1'b1;
        #1;
        check("mid_reset_outputs", 64'({busy, done, err, we, flags_we, flag_n, flag_z, ra1, ra2, wa}), 64'(0));
        check("mid_reset_wd", 64'(wd), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        check("mid_reset_no_write", 64'(nwrites - w0), 64'(0));
        check("mid_reset_reg", 64'(regs[14]), 64'(32'd4));

        expect_write(4'd2, 32'd42);
        run_op("mul_after_reset", mk(3'b000, 1'b1, 4'd2, 4'd0, 4'd4, 4'd3), 35, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);

        // Same MUL on the four-bits-per-cycle instance.
        @(negedge clk);
        instr4 = mk(3'b000, 1'b1, 4'd2, 4'd0, 4'd4, 4'd3);
        start4 = 1'b1;
        for (n = 1; n <= 100; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 1) start4 = 1'b0;
            if (done4 === 1'b1) break;
        end
        check("bpc4_latency", 64'(n), 64'(11));
        check("bpc4_write", 64'({we4, wa4, wd4}), 64'({1'b1, 4'd2, 32'd42}));
        check("bpc4_flags", 64'({flags_we4, flag_n4, flag_z4, err4}), 64'({1'b1, 1'b0, 1'b0, 1'b0}));
        @(negedge clk);
        check("bpc4_reg", 64'(regs4[2]), 64'(32'd42));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
